// File: rtl/rv32i_enc.sv
// rv32i_enc: streaming RV32I instruction encoder with output FIFO.
//   Packs {fmt, opcode, rd, rs1, rs2, funct3, funct7, imm} tuples into 32-bit
//   instruction words. Each word is queued together with a sequential word
//   address, which starts at BASE_ADDR and steps by 4.
// Ports:
//   clk, rst (async, active-high), flush (sync clear of FIFO and address)
//   in_valid/in_ready + in_* fields   : tuple input
//   out_valid/out_ready, out_instr/out_addr : FIFO head
//   count : FIFO occupancy; err : one-cycle pulse for a dropped tuple
// Config macro: RV32I_ENC_IMM_CHECK_EN enables range checking of in_imm.
module rv32i_enc #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_fmt,
  input  logic [6:0]                    in_opcode,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_rs1,
  input  logic [4:0]                    in_rs2,
  input  logic [2:0]                    in_funct3,
  input  logic [6:0]                    in_funct7,
  input  logic [31:0]                   in_imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [31:0]                   out_addr,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  // Each entry holds {instr, addr}.
  logic [FIFO_DEPTH-1:0][63:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic [31:0]                 addr_q, addr_d;
  logic [63:0]                 last_q, last_d;
  logic                        err_q, err_d;

  logic [6:0]  op;
  logic [31:0] enc;
  logic        legal, accept, push, pop;

  // Opcode bits [1:0] are always forced to 2'b11.
  logic unused_ok;
  assign unused_ok = ^in_opcode[1:0];

  assign op = {in_opcode[6:2], 2'b11};

  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    case (in_fmt)
      3'd0: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, op};
      3'd1: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, op};
      3'd2: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], op};
      3'd3: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], op};
      3'd4: enc = {in_imm[31:12], in_rd, op};
      3'd5: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
      default: legal = 1'b0;
    endcase
`ifdef RV32I_ENC_IMM_CHECK_EN
    case (in_fmt)
      3'd1, 3'd2: if (in_imm[31:11] != {21{in_imm[11]}}) legal = 1'b0;
      3'd3: if (in_imm[31:12] != {20{in_imm[12]}} || in_imm[0]) legal = 1'b0;
      3'd4: if (in_imm[11:0] != 12'h0) legal = 1'b0;
      3'd5: if (in_imm[31:20] != {12{in_imm[20]}} || in_imm[0]) legal = 1'b0;
      default: ;
    endcase
`endif
  end

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  // Flush wins over everything presented in the same cycle, including err.
  assign push      = accept && legal && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    // Remember the current head so the outputs hold once the FIFO drains.
    last_d   = out_valid ? mem_q[rd_ptr_q] : last_q;
    err_d    = accept && !legal && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {enc, addr_q};
        wr_ptr_d        = wr_ptr_q + 1'b1;
        addr_d          = addr_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      last_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign out_instr = out_valid ? mem_q[rd_ptr_q][63:32] : last_q[63:32];
  assign out_addr  = out_valid ? mem_q[rd_ptr_q][31:0]  : last_q[31:0];
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rv32i_enc.sv
// Directed bench for rv32i_enc (FIFO_DEPTH=4, BASE_ADDR=0).
module tb_rv32i_enc;
  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr, out_addr;
  logic [2:0]  count;
  int checks = 0;
  int errors = 0;

  rv32i_enc #(.FIFO_DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send();
    in_valid = 1'b1; step(); in_valid = 1'b0;
  endtask

  task automatic addi(input logic [31:0] imm);
    set_in(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm);
  endtask

  task automatic do_flush();
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Round trips
    out_ready = 1'b1;
    addi(32'd5); send();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_instr", out_instr, 32'h00500093);
    chk("addi_addr", out_addr, 32'h0);
    set_in(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0); send();
    chk("add_instr", out_instr, 32'h002081B3);
    chk("add_addr", out_addr, 32'h4);
    chk("add_count", 32'(count), 32'd1);
    step();
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_hold_instr", out_instr, 32'h002081B3);
    chk("empty_hold_addr", out_addr, 32'h4);
    set_in(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8); send();
    chk("beq_instr", out_instr, 32'hFE208CE3);
    chk("beq_addr", out_addr, 32'h8);
    set_in(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16); send();
    chk("jal_instr", out_instr, 32'h010000EF);
    chk("jal_addr", out_addr, 32'hC);
    step();

    // Backpressure
    do_flush();
    chk("flush_count", 32'(count), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin addi(32'(i)); send(); end
    chk("bp_count_full", 32'(count), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    addi(32'd4); in_valid = 1'b1;
    step(); step();
    chk("bp_count_held", 32'(count), 32'd4);
    chk("bp_head_instr", out_instr, 32'h00000093);
    chk("bp_head_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    step();
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    chk("bp_count_3", 32'(count), 32'd3);
    chk("bp_addr_4", out_addr, 32'h4);
    step(); in_valid = 1'b0;
    chk("bp_addr_8", out_addr, 32'h8);
    chk("bp_count_push_pop", 32'(count), 32'd3);
    step();
    chk("bp_addr_C", out_addr, 32'hC);
    step();
    chk("bp_addr_10", out_addr, 32'h10);
    chk("bp_instr_5th", out_instr, 32'h00400093);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Illegal format between two legal tuples
    do_flush();
    out_ready = 1'b0;
    addi(32'd1); send();
    set_in(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); send();
    chk("ill_err_pulse", 32'(err), 32'd1);
    chk("ill_count", 32'(count), 32'd1);
    step();
    chk("ill_err_clear", 32'(err), 32'd0);
    addi(32'd2); send();
    chk("ill_count2", 32'(count), 32'd2);
    out_ready = 1'b1; step();
    chk("ill_second_addr", out_addr, 32'h4);
    chk("ill_second_instr", out_instr, 32'h00200093);
    step();

    // Flush with a tuple presented in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin addi(32'(i)); send(); end
    chk("fl_count3", 32'(count), 32'd3);
    addi(32'd9); in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_count0", 32'(count), 32'd0);
    chk("fl_valid0", 32'(out_valid), 32'd0);
    chk("fl_no_err", 32'(err), 32'd0);
    addi(32'd7); send();
    chk("fl_next_addr", out_addr, 32'h0);
    chk("fl_next_instr", out_instr, 32'h00700093);
    out_ready = 1'b1; step();

    // I-type imm=2048
    addi(32'd2048); send();
`ifdef RV32I_ENC_IMM_CHECK_EN
    chk("imm_err", 32'(err), 32'd1);
    chk("imm_no_emit", 32'(out_valid), 32'd0);
`else
    chk("imm_no_err", 32'(err), 32'd0);
    chk("imm_emit_instr", out_instr, 32'h80000093);
    chk("imm_emit_addr", out_addr, 32'h4);
`endif
    step();

    // Async reset mid-drain
    out_ready = 1'b0;
    addi(32'd3); send(); addi(32'd4); send();
    chk("ar_count2", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_instr", out_instr, 32'h0);
    chk("ar_addr", out_addr, 32'h0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    addi(32'd6); send();
    chk("ar_next_addr", out_addr, 32'h0);
    chk("ar_next_instr", out_instr, 32'h00600093);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_enc.md
Name: rv32i_enc

Overview:
- Streaming RV32I instruction encoder: packs format/field tuples into 32-bit instruction words, the inverse of the team's RV32I decoder.
- Encoded words are buffered in a small FIFO and emitted with a sequential word address.
- Used by the test-program loader and self-check harness to feed instruction memory, so every encoder/decoder pair round-trips.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
- BASE_ADDR, 32'h0000_0000, address of the first emitted word after reset or flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of FIFO and address counter.
- in_valid  in  1  input tuple valid.
- in_ready  out  1  encoder can accept a tuple.
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 are illegal.
- in_opcode  in  7  opcode; bits [1:0] are ignored and forced to 2'b11.
- in_rd, in_rs1, in_rs2  in  5  register indices.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R only).
- in_imm  in  32  immediate in the decoder's sign-extended, byte-offset form.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded word.
- out_addr  out  32  word address.
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- err  out  1  one-cycle pulse when an accepted tuple is dropped.

Behaviour:
- Reset values: FIFO empty, count=0, out_valid=0, out_instr=0, out_addr=0, err=0, address counter=BASE_ADDR, in_ready=1.
- Reset asserted mid-operation discards all FIFO contents immediately.
- Input accept: in_valid && in_ready.
- in_ready = (count != FIFO_DEPTH), independent of in_valid.
- Encoding (op = {in_opcode[6:2], 2'b11}):
  - R: {funct7, rs2, rs1, funct3, rd, op}
  - I: {imm[11:0], rs1, funct3, rd, op}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - Unused fields are ignored.
- Push: each accepted legal tuple pushes {encoded word, address counter}; the counter then advances by 4.
- Counter wrap: wraps modulo 2^32 with no flag.
- Illegal in_fmt (6 or 7): tuple is accepted but not pushed. The address counter does not advance, and err pulses high for exactly the following cycle.
- Latency: a pushed word appears at the FIFO head, with out_valid=1, on the cycle after acceptance. There is no combinational bypass.
- Pop: out_valid && out_ready.
  - out_instr/out_addr hold stable while out_valid && !out_ready.
  - When empty, out_valid=0 and out_instr/out_addr hold their last value.
- Simultaneous push and pop: allowed whenever not full; count is unchanged.
- Full: no push. A pop in that cycle makes in_ready=1 the next cycle.
- Ordering: strictly FIFO.
- flush: on a clock edge with flush=1, the FIFO empties, count=0, and the counter returns to BASE_ADDR.
  - Flush dominates any same-cycle push or pop; a tuple presented that cycle is discarded.
  - No err is generated for the discarded tuple.

Optional Feature:
- RV32I_ENC_IMM_CHECK_EN defined: in_imm is range-checked. The tuple is dropped with an err pulse (counter not advanced) when:
  - I/S: imm is not 12-bit sign-extended.
  - B: imm is not 13-bit sign-extended, or imm[0]=1.
  - J: imm is not 21-bit sign-extended, or imm[0]=1.
  - U: imm[11:0]!=0.
- RV32I_ENC_IMM_CHECK_EN undefined: no immediate check; out-of-range bits are silently truncated and err fires only for illegal in_fmt.

Test Plan:
- Round-trip encodes after reset, each checked at out_instr/out_addr:
  - ADDI x1,x0,5 (fmt=1, opcode=0010011, rd=1, imm=5) -> 0x00500093 @ 0x0.
  - ADD x3,x1,x2 (fmt=0, opcode=0110011) -> 0x002081B3 @ 0x4.
- Branch/jump encodes:
  - BEQ x1,x2,-8 (fmt=3, opcode=1100011, imm=32'hFFFFFFF8) -> 0xFE208CE3.
  - JAL x1,16 (fmt=5, opcode=1101111, imm=16) -> 0x010000EF.
- Backpressure: hold out_ready=0 and push 5 legal tuples.
  - in_ready drops after the 4th; count=4; the 5th tuple is held.
  - Release out_ready: words drain in order at 0x0, 0x4, 0x8, 0xC, then 0x10.
- Illegal format: push fmt=7 between two legal tuples.
  - err pulses for 1 cycle; the second legal word gets address 0x4, not 0x8.
- Flush and reset:
  - Fill 3 entries, then flush together with in_valid=1: count=0, out_valid=0; the next push emits @ BASE_ADDR.
  - Assert rst asynchronously mid-drain: outputs go to reset values before the next clock edge.
- Macro on: I-type imm=2048 -> err pulse, nothing emitted. Macro off: the same stimulus emits 0x80000093 (rd=1, rs1=0).
